// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: pipeline MEM stage. Resolves beq/bne, performs byte/half/
// word(/double) loads and stores against an internal byte-lane RAM whose
// access takes MEM_LAT cycles, stalls upstream while an access is in flight,
// and registers results into the MEM/WB register.
// Optional feature: define MEM_STAGE_ALIGN_CHECK_EN to trap misaligned
// accesses (single-cycle, RAM untouched, regwrite suppressed, misalign flag)
// instead of masking the offset down to natural alignment.

// One byte lane of the data RAM. Read is combinational; the access latency
// is modelled by the stage's cycle counter, not by the array itself.
module mem_stage_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] ram [0:(1<<ADDR_W)-1];

  // byte write on the completion edge of a store
  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
  end

  assign rdata = ram[addr];
endmodule

module mem_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int REG_W   = 5,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        wb_ctl,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  write_reg,
  output logic              stall,
  output logic              pcsrc,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic              misalign
);
  localparam int NB    = DATA_W / 8;
  localparam int L     = $clog2(NB);
  localparam int IW    = $clog2(DATA_W);
  localparam int CNT_W = 3;  // MEM_LAT <= 8, so cnt never exceeds 7
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0]      cnt;
  logic                  memop, last, done, mis, ram_we;
  logic [1:0]            eff_size;
  logic [L-1:0]          off, size_mask, acc_off;
  logic [ADDR_W-1:0]     word_idx;
  logic [NB-1:0]         lane_sel;
  logic [NB-1:0][7:0]    wbyte, rword;
  logic [DATA_W-1:0]     rflat, shifted, load_val, rd_val;
  logic [IW-1:0]         msb;
  logic                  sgn;

  assign pcsrc    = in_valid & branch & (zero ^ branch_ne);
  assign memop    = in_valid & (memread | memwrite);
  assign word_idx = alu_result[ADDR_W+L-1:L];
  assign off      = alu_result[L-1:0];

  // doubleword size on a 32-bit datapath is illegal; clamp it to a full word
  assign eff_size  = (size > 2'(L)) ? 2'(L) : size;
  assign size_mask = L'((1 << eff_size) - 1);
  assign acc_off   = off & ~size_mask;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(off & size_mask);
  assign mis        = memop & misaligned;
`else
  assign mis = 1'b0;
`endif

  assign last   = (cnt == LAST);
  assign stall  = memop & ~mis & ~last;
  assign done   = memop & (mis | last);
  // reset on the completion edge drops the pending store
  assign ram_we = done & memwrite & ~mis & ~rst;

  // lane i belongs to the access when its aligned group base equals the
  // access offset; its store byte is the matching right-justified source byte
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lane_sel[i] = ((L'(i) & ~size_mask) == acc_off);
    assign wbyte[i]    = store_data[{L'(i) & size_mask, 3'b000} +: 8];

    mem_stage_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .we    (ram_we & lane_sel[i]),
      .addr  (word_idx),
      .wdata (wbyte[i]),
      .rdata (rword[i])
    );
  end

  assign rflat = rword;

  // right-justify the selected lanes, then sign- or zero-extend
  always_comb begin
    shifted  = rflat >> {acc_off, 3'b000};
    msb      = IW'((8 << eff_size) - 1);
    sgn      = ~load_unsigned & shifted[msb];
    load_val = '0;
    for (int j = 0; j < DATA_W; j++)
      load_val[j] = (IW'(j) <= msb) ? shifted[j] : sgn;
  end

  // a combined read+write reports zero read data; trapped accesses read zero
  assign rd_val = (memop & memread & ~memwrite & ~mis) ? load_val : '0;

  // access latency counter: counts stalled cycles, clears on completion
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (stall) cnt <= cnt + CNT_W'(1);
    else            cnt <= '0;
  end

  // MEM/WB register: bubble while stalled, load everything otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_write_reg  <= '0;
      misalign      <= 1'b0;
    end else if (stall) begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      wb_valid      <= in_valid;
      wb_regwrite   <= wb_ctl[1] & ~mis;
      wb_memtoreg   <= wb_ctl[0];
      wb_read_data  <= rd_val;
      wb_alu_result <= alu_result;
      wb_write_reg  <= write_reg;
      misalign      <= mis;
    end
  end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: one MEM_LAT=3 instance checked through a
// scoreboard monitor, one MEM_LAT=1 instance for the no-stall stream.
module tb_mem_stage_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 0, branch = 0, branch_ne = 0, memread = 0, memwrite = 0;
  logic        load_unsigned = 0, zero = 0;
  logic [1:0]  wb_ctl = 0, size = 0;
  logic [31:0] alu_result = 0, store_data = 0;
  logic [4:0]  write_reg = 0;

  logic        stall3, pcsrc3, wb_valid3, wb_regwrite3, wb_memtoreg3, misalign3;
  logic [31:0] wb_read_data3, wb_alu_result3;
  logic [4:0]  wb_write_reg3;
  logic        stall1, pcsrc1, wb_valid1, wb_regwrite1, wb_memtoreg1, misalign1;
  logic [31:0] wb_read_data1, wb_alu_result1;
  logic [4:0]  wb_write_reg1;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw;
    logic        m2r;
    logic        mis;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];
  exp_t mon_e;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic mon_en = 1'b1;

  always #5 clk = ~clk;

  mem_stage_pipe #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctl(wb_ctl), .branch(branch),
    .branch_ne(branch_ne), .memread(memread), .memwrite(memwrite), .size(size),
    .load_unsigned(load_unsigned), .zero(zero), .alu_result(alu_result),
    .store_data(store_data), .write_reg(write_reg), .stall(stall3), .pcsrc(pcsrc3),
    .wb_valid(wb_valid3), .wb_regwrite(wb_regwrite3), .wb_memtoreg(wb_memtoreg3),
    .wb_read_data(wb_read_data3), .wb_alu_result(wb_alu_result3),
    .wb_write_reg(wb_write_reg3), .misalign(misalign3));

  mem_stage_pipe #(.DATA_W(32), .ADDR_W(10), .REG_W(5), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctl(wb_ctl), .branch(branch),
    .branch_ne(branch_ne), .memread(memread), .memwrite(memwrite), .size(size),
    .load_unsigned(load_unsigned), .zero(zero), .alu_result(alu_result),
    .store_data(store_data), .write_reg(write_reg), .stall(stall1), .pcsrc(pcsrc1),
    .wb_valid(wb_valid1), .wb_regwrite(wb_regwrite1), .wb_memtoreg(wb_memtoreg1),
    .wb_read_data(wb_read_data1), .wb_alu_result(wb_alu_result1),
    .wb_write_reg(wb_write_reg1), .misalign(misalign1));

  // scoreboard monitor for the MEM_LAT=3 instance: every wb_valid pops one entry
  always @(negedge clk) begin
    if (mon_en && wb_valid3 === 1'b1) begin
      chk_cnt++;
      if (q3.size() == 0) begin
        $display("FAIL sb_unexpected: wb_valid with alu=%h, expected no output", wb_alu_result3);
      end else begin
        mon_e = q3.pop_front();
        if (wb_read_data3 !== mon_e.rd || wb_alu_result3 !== mon_e.alu ||
            wb_write_reg3 !== mon_e.wr || wb_regwrite3 !== mon_e.rw ||
            wb_memtoreg3 !== mon_e.m2r || misalign3 !== mon_e.mis)
          $display("FAIL sb_wb: got rd=%h alu=%h wr=%0d rw=%b m2r=%b mis=%b, expected rd=%h alu=%h wr=%0d rw=%b m2r=%b mis=%b",
                   wb_read_data3, wb_alu_result3, wb_write_reg3, wb_regwrite3, wb_memtoreg3, misalign3,
                   mon_e.rd, mon_e.alu, mon_e.wr, mon_e.rw, mon_e.m2r, mon_e.mis);
        else pass_cnt++;
      end
    end
  end

  task automatic drive(input logic v, input logic rd_, input logic wr_, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r, input logic [1:0] ctl);
    in_valid = v; memread = rd_; memwrite = wr_; size = sz; load_unsigned = uns;
    alu_result = a; store_data = sd; write_reg = r; wb_ctl = ctl;
    branch = 0; branch_ne = 0; zero = 0;
  endtask

  task automatic push3(input logic [31:0] rd, input logic [31:0] a, input logic [4:0] r,
                       input logic [1:0] ctl, input logic mis);
    exp_t e;
    e.rd = rd; e.alu = a; e.wr = r; e.rw = ctl[1] & ~mis; e.m2r = ctl[0]; e.mis = mis;
    q3.push_back(e);
  endtask

  // issue one memory op to dut3 and hold it until it completes; returns stall cycles
  task automatic do_op(input logic rd_, input logic wr_, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                       input logic [1:0] ctl, input logic [31:0] exp_rd, input logic exp_mis,
                       output int nst);
    @(negedge clk);
    drive(1'b1, rd_, wr_, sz, uns, a, sd, r, ctl);
    push3(exp_rd, a, r, ctl, exp_mis);
    nst = 0;
    #1;
    while (stall3 === 1'b1 && nst < 20) begin
      @(posedge clk); #1; nst++;
    end
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_cnt++;
    if (wb_valid3 !== 0 || wb_regwrite3 !== 0 || wb_memtoreg3 !== 0 || wb_read_data3 !== 0 ||
        wb_alu_result3 !== 0 || wb_write_reg3 !== 0 || misalign3 !== 0)
      $display("FAIL reset_wb: got v=%b rw=%b m2r=%b rd=%h alu=%h wr=%0d mis=%b, expected all 0",
               wb_valid3, wb_regwrite3, wb_memtoreg3, wb_read_data3, wb_alu_result3, wb_write_reg3, misalign3);
    else pass_cnt++;
    drive(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd1, 2'b11);
    #1;
    chk_cnt++;
    if (stall3 !== 1'b1) $display("FAIL reset_stall: got %b expected 1", stall3);
    else pass_cnt++;
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int n;
    do_op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0, 2'b00, 32'h0, 0, n);
    chk_cnt++;
    if (n !== 2) $display("FAIL sw_stalls: got %0d expected 2", n); else pass_cnt++;
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd5, 2'b11, 32'hDEADBEEF, 0, n);
    chk_cnt++;
    if (n !== 2) $display("FAIL lw_stalls: got %0d expected 2", n); else pass_cnt++;
  endtask

  task automatic test_sub_word();
    int n, tot;
    tot = 0;
    do_op(0, 1, 2'b00, 0, 32'h13, 32'h00000080, 5'd0, 2'b00, 32'h0, 0, n);         tot += n;
    do_op(1, 0, 2'b00, 0, 32'h13, 32'h0, 5'd7, 2'b11, 32'hFFFFFF80, 0, n);         tot += n;
    do_op(1, 0, 2'b00, 1, 32'h13, 32'h0, 5'd8, 2'b11, 32'h00000080, 0, n);         tot += n;
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd9, 2'b11, 32'h80ADBEEF, 0, n);         tot += n;
    do_op(1, 0, 2'b01, 0, 32'h12, 32'h0, 5'd10, 2'b11, 32'hFFFF80AD, 0, n);        tot += n;
    do_op(1, 0, 2'b01, 1, 32'h10, 32'h0, 5'd11, 2'b11, 32'h0000BEEF, 0, n);        tot += n;
    chk_cnt++;
    if (tot !== 12) $display("FAIL subword_stalls: got %0d expected 12", tot); else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [3:0] tbl [5];
    tbl[0] = 4'b1011; tbl[1] = 4'b1110; tbl[2] = 4'b1101; tbl[3] = 4'b1000; tbl[4] = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(tbl[i][3], 0, 0, 2'b00, 0, 32'h100 + i, 32'h0, 5'd2, 2'b00);
      branch = 1'b1; branch_ne = tbl[i][2]; zero = tbl[i][1];
      if (tbl[i][3]) push3(32'h0, 32'h100 + i, 5'd2, 2'b00, 0);
      #1;
      chk_cnt++;
      if (pcsrc3 !== tbl[i][0] || stall3 !== 1'b0)
        $display("FAIL branch_%0d: got pcsrc=%b stall=%b expected pcsrc=%b stall=0", i, pcsrc3, stall3, tbl[i][0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_invalid_memop();
    int n;
    @(negedge clk);
    drive(0, 0, 1, 2'b10, 0, 32'h10, 32'h0, 5'd0, 2'b00);
    #1;
    chk_cnt++;
    if (stall3 !== 1'b0) $display("FAIL invalid_stall: got %b expected 0", stall3); else pass_cnt++;
    repeat (3) @(posedge clk);
    do_op(1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd12, 2'b11, 32'h80ADBEEF, 0, n);
  endtask

  task automatic test_reset_abort();
    int n;
    do_op(0, 1, 2'b10, 0, 32'h20, 32'h1234C321, 5'd0, 2'b00, 32'h0, 0, n);
    @(negedge clk);
    drive(1, 0, 1, 2'b10, 0, 32'h20, 32'h22222222, 5'd0, 2'b00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (wb_valid3 !== 0 || wb_read_data3 !== 0 || wb_alu_result3 !== 0 || wb_write_reg3 !== 0 ||
        wb_regwrite3 !== 0 || wb_memtoreg3 !== 0 || misalign3 !== 0)
      $display("FAIL abort_wb: got v=%b rd=%h alu=%h wr=%0d rw=%b m2r=%b mis=%b expected all 0",
               wb_valid3, wb_read_data3, wb_alu_result3, wb_write_reg3, wb_regwrite3, wb_memtoreg3, misalign3);
    else pass_cnt++;
    chk_cnt++;
    if (stall3 !== 1'b1) $display("FAIL abort_cnt_clear: stall got %b expected 1", stall3); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 2'b00);
    @(posedge clk);
    do_op(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd13, 2'b11, 32'h1234C321, 0, n);
  endtask

  task automatic test_align();
    int n1, n2, n3;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    do_op(1, 0, 2'b01, 0, 32'h21, 32'h0, 5'd14, 2'b11, 32'h0, 1, n1);
    do_op(0, 1, 2'b01, 0, 32'h21, 32'h0000FFFF, 5'd0, 2'b00, 32'h0, 1, n2);
    do_op(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd15, 2'b11, 32'h1234C321, 0, n3);
    chk_cnt++;
    if (n1 !== 0 || n2 !== 0 || n3 !== 2)
      $display("FAIL align_stalls: got %0d/%0d/%0d expected 0/0/2", n1, n2, n3);
    else pass_cnt++;
`else
    do_op(1, 0, 2'b01, 0, 32'h21, 32'h0, 5'd14, 2'b11, 32'hFFFFC321, 0, n1);
    do_op(0, 1, 2'b01, 0, 32'h21, 32'h0000FFFF, 5'd0, 2'b00, 32'h0, 0, n2);
    do_op(1, 0, 2'b10, 0, 32'h20, 32'h0, 5'd15, 2'b11, 32'h1234FFFF, 0, n3);
    chk_cnt++;
    if (n1 !== 2 || n2 !== 2 || n3 !== 2)
      $display("FAIL align_stalls: got %0d/%0d/%0d expected 2/2/2", n1, n2, n3);
    else pass_cnt++;
`endif
    go_idle();
    chk_cnt++;
    if (q3.size() !== 0) $display("FAIL sb_drain: got %0d pending expected 0", q3.size());
    else pass_cnt++;
  endtask

  task automatic test_lat1_stream();
    logic [1:0]  kind [6];   // 0 add, 1 sw, 2 lw
    logic [31:0] addr [6];
    logic [31:0] dat  [6];
    exp_t e;
    kind[0] = 0; addr[0] = 32'h5;  dat[0] = 32'h0;
    kind[1] = 1; addr[1] = 32'h40; dat[1] = 32'hCAFEF00D;
    kind[2] = 2; addr[2] = 32'h40; dat[2] = 32'hCAFEF00D;
    kind[3] = 0; addr[3] = 32'h7;  dat[3] = 32'h0;
    kind[4] = 1; addr[4] = 32'h44; dat[4] = 32'h0BADF00D;
    kind[5] = 2; addr[5] = 32'h44; dat[5] = 32'h0BADF00D;
    mon_en = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = q1.pop_front();
        chk_cnt++;
        if (wb_valid1 !== 1'b1 || wb_read_data1 !== e.rd || wb_alu_result1 !== e.alu ||
            wb_write_reg1 !== e.wr || wb_regwrite1 !== e.rw)
          $display("FAIL lat1_wb_%0d: got v=%b rd=%h alu=%h wr=%0d rw=%b expected v=1 rd=%h alu=%h wr=%0d rw=%b",
                   i - 1, wb_valid1, wb_read_data1, wb_alu_result1, wb_write_reg1, wb_regwrite1,
                   e.rd, e.alu, e.wr, e.rw);
        else pass_cnt++;
      end
      if (i < 6) begin
        case (kind[i])
          2'd0: drive(1, 0, 0, 2'b00, 0, addr[i], 32'h0, 5'd3, 2'b10);
          2'd1: drive(1, 0, 1, 2'b10, 0, addr[i], dat[i], 5'd0, 2'b00);
          default: drive(1, 1, 0, 2'b10, 0, addr[i], 32'h0, 5'd4, 2'b11);
        endcase
        e.rd  = (kind[i] == 2) ? dat[i] : 32'h0;
        e.alu = addr[i];
        e.wr  = (kind[i] == 0) ? 5'd3 : (kind[i] == 1) ? 5'd0 : 5'd4;
        e.rw  = (kind[i] != 1);
        e.m2r = (kind[i] == 2);
        e.mis = 1'b0;
        q1.push_back(e);
        #1;
        chk_cnt++;
        if (stall1 !== 1'b0) $display("FAIL lat1_stall_%0d: got %b expected 0", i, stall1);
        else pass_cnt++;
      end else begin
        drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 2'b00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_sub_word();
    test_branch();
    test_invalid_memop();
    test_reset_abort();
    test_align();
    test_lat1_stream();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised pipeline MEM stage that replaces the single-cycle memory stage. It resolves branches (beq/bne), performs byte/half/word loads and stores against an internal data RAM with configurable access latency, stalls upstream while an access is in flight, and registers results into the MEM/WB pipeline register. It sits between the EX/MEM register and the write-back stage.

## Interface
Parameters:
- DATA_W, 32: datapath width. Legal values are 32 or 64.
- ADDR_W, 10: word-address bits. RAM depth is 2^ADDR_W words of DATA_W.
- REG_W, 5: destination register index width.
- MEM_LAT, 2: cycles per memory access. Range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- wb_ctl  in  2  {regwrite, memtoreg}
- branch  in  1  branch instruction
- branch_ne  in  1  1 = bne, 0 = beq
- memread, memwrite  in  1 each  memory op select
- size  in  2  00 byte, 01 half, 10 word; 11 doubleword (legal only when DATA_W=64)
- load_unsigned  in  1  zero-extend loads
- zero  in  1  ALU zero flag
- alu_result  in  DATA_W  byte address / ALU value
- store_data  in  DATA_W  store source, right-justified
- write_reg  in  REG_W  destination register
- stall  out  1  hold EX/MEM and earlier stages
- pcsrc  out  1  take branch
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each
- wb_read_data, wb_alu_result  out  DATA_W
- wb_write_reg  out  REG_W
- misalign  out  1  registered alignment fault flag

## Operation
- pcsrc is combinational: in_valid & branch & (zero ^ branch_ne). Branches never stall.
- Memory op: in_valid & (memread | memwrite).
- Internal counter cnt has two states:
  - IDLE: cnt = 0.
  - WAIT: cnt > 0.
- stall = memop & (cnt != MEM_LAT-1). Each stalled cycle, cnt increments. Upstream holds all inputs stable while stall=1.
- Completion edge: the edge where memop & cnt == MEM_LAT-1.
  - The store is written at this edge.
  - The load result is registered at this edge.
  - cnt returns to 0.
- With MEM_LAT=1, stall is never asserted.
- Addressing:
  - Word index = alu_result[ADDR_W+L-1:L], where L = log2(DATA_W/8).
  - Lane offset = alu_result[L-1:0].
  - Higher address bits are ignored, so addresses wrap.
- Stores modify only the lanes selected by size and offset. Other lanes are preserved.
- Loads extract the selected lanes. They are sign-extended to DATA_W, or zero-extended when load_unsigned=1.
- If memread and memwrite are both set, the write takes effect and wb_read_data = 0.
- MEM/WB register, non-stalled cycle: loads wb_ctl, read data, alu_result and write_reg. wb_valid = in_valid.
- MEM/WB register, stalled cycle: wb_valid = 0 (bubble). All other wb_* outputs hold their values.
- RAM contents are not affected by rst. Initial contents are zero in simulation.

## Timing
- Non-memory instruction: 1 cycle through the stage. Results visible on wb_* after the next edge.
- Memory instruction: MEM_LAT cycles, of which MEM_LAT-1 are stall cycles. wb_valid=1 for exactly one cycle after the completion edge.
- Back-to-back memory ops: the next op starts counting from cnt=0 in the cycle after completion. No dead cycle.
- Reset values: all wb_* = 0, misalign = 0, cnt = 0, stall reflects inputs with cnt=0.
- Reset during WAIT: cnt clears and the pending store is dropped. No wb_valid is produced for the aborted op.
- in_valid=0 with memread/memwrite set: no stall, no RAM write.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN defined:
  - A misaligned access (offset not a multiple of the access size) completes in one cycle with no stall.
  - The RAM is untouched.
  - wb_regwrite is forced to 0.
  - misalign=1 together with that wb_valid pulse.
- MEM_STAGE_ALIGN_CHECK_EN undefined:
  - Offset low bits are masked down to natural alignment and the access proceeds normally.
  - misalign is tied to 0.

## Test plan
- MEM_LAT=3, sw 0xDEADBEEF to 0x10, then lw 0x10 → stall high for 2 cycles per op; wb_read_data=0xDEADBEEF with wb_valid pulsed once per op.
- sb 0x80 to 0x13, then lb 0x13 and lbu 0x13 → 0xFFFFFF80, then 0x00000080; the other three bytes of word 0x10 are unchanged.
- beq with zero=1 → pcsrc=1. bne with zero=1 → pcsrc=0. in_valid=0 → pcsrc=0.
- Assert rst on the second WAIT cycle of a sw to 0x20 → the later lw 0x20 returns the old value; wb_* read 0 after reset.
- lh at 0x21 with MEM_STAGE_ALIGN_CHECK_EN → misalign=1, wb_regwrite=0, stall=0. Without the macro → returns the half at 0x20.
- MEM_LAT=1, alternating add/lw/sw stream → stall never asserts; wb_valid=1 every cycle.
